// File: rtl/instr_encoder_pkg.sv
// Shared constants for the MIPS instruction encoder: op-class codes, the
// 6-bit primary opcodes they map to, the encoder session states and the
// packing helpers. The opcode decoder uses the same opcode constants, so
// encode and decode cannot drift apart.
package instr_encoder_pkg;

  // Primary opcode field values (instruction bits [31:26])
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_BEQ   = 6'h04;

  // Op-class code carried on the instruction input bus
  typedef enum logic [2:0] {
    OP_R       = 3'd0,
    OP_ADDI    = 3'd1,
    OP_ANDI    = 3'd2,
    OP_ORI     = 3'd3,
    OP_SW      = 3'd4,
    OP_LW      = 3'd5,
    OP_BEQ     = 3'd6,
    OP_ILLEGAL = 3'd7
  } op_class_e;

  // Load-session states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ERR   = 2'd3
  } enc_state_e;

  // One instruction description as presented on the input bus
  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
  } instr_fields_t;

  // True for every op class that produces an instruction word
  function automatic logic is_legal_op(logic [2:0] op);
    return (op != OP_ILLEGAL);
  endfunction

  // Map an I-type op class to its primary opcode; R-type and the illegal
  // code fall back to OPC_RTYPE (the illegal code never reaches the FIFO).
  function automatic logic [5:0] op_to_opcode(logic [2:0] op);
    logic [5:0] opc;
    case (op_class_e'(op))
      OP_ADDI: opc = OPC_ADDI;
      OP_ANDI: opc = OPC_ANDI;
      OP_ORI:  opc = OPC_ORI;
      OP_SW:   opc = OPC_SW;
      OP_LW:   opc = OPC_LW;
      OP_BEQ:  opc = OPC_BEQ;
      default: opc = OPC_RTYPE;
    endcase
    return opc;
  endfunction

  // Pack a description into a 32-bit MIPS word. Fields that the format
  // does not use (rd/shamt/funct for I-types, imm for R-type) are dropped.
  function automatic logic [31:0] encode_instr(instr_fields_t f);
    logic [31:0] word;
    if (f.op == OP_R) begin
      word = {OPC_RTYPE, f.rs, f.rt, f.rd, f.shamt, f.funct};
    end else begin
      word = {op_to_opcode(f.op), f.rs, f.rt, f.imm};
    end
    return word;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Instruction-in and imem-write handshake bundle of the instruction encoder.
// The master side is the producer of instruction descriptions and the
// consumer of imem writes (bench / boot loader); the slave side is the
// encoder itself.
interface instr_encoder_if #(
  parameter int ADDR_W = 10
);

  // Instruction description handshake
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_op;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [5:0]        in_funct;
  logic [15:0]       in_imm;

  // Instruction-memory write handshake
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm,
    input  in_ready,
    input  wr_valid, wr_addr, wr_data,
    output wr_ready
  );

  modport slave (
    input  in_valid, in_op, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm,
    output in_ready,
    output wr_valid, wr_addr, wr_data,
    input  wr_ready
  );

endinterface

// File: rtl/instr_encoder_sync_fifo.sv
// Small synchronous FIFO holding encoded instruction words between the
// input handshake and the imem write port. The head word is read straight
// from the storage registers, so there is never a path from data_i to
// data_o within a cycle. Storage is cleared on reset so the head reads 0.
module instr_encoder_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   cnt_q;
  logic             do_push_s;
  logic             do_pop_s;

  // Requests are qualified here so a caller can never overrun or underrun
  assign full_o    = (cnt_q == DEPTH_C);
  assign empty_o   = (cnt_q == '0);
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;
  assign data_o    = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts instruction descriptions during a load
// session, packs them into 32-bit MIPS words and streams them through a
// small FIFO to sequential instruction-memory addresses starting at the
// session base address. An illegal op class aborts the session after the
// words already queued have been written.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 2
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              finish_i,
  instr_encoder_if.slave    bus,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   count_o
);

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              err_q, err_d;
  logic              done_q, done_d;

  instr_fields_t     fields_s;
  logic [31:0]       encoded_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              illegal_s;
  logic              push_s;
  logic              pop_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [31:0]       fifo_head_s;

  // Gather the input fields and encode them; the word only lands in the FIFO
  assign fields_s  = {bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd,
                      bus.in_shamt, bus.in_funct, bus.in_imm};
  assign encoded_s = encode_instr(fields_s);

  // Input handshake: only a load session with FIFO space accepts
  assign in_ready_s = (state_q == ST_LOAD) && !fifo_full_s;
  assign accept_s   = bus.in_valid && in_ready_s;
  assign illegal_s  = accept_s && !is_legal_op(bus.in_op);
  assign push_s     = accept_s && !illegal_s;

  // A write completes whenever a queued word meets wr_ready
  assign pop_s = !fifo_empty_s && bus.wr_ready;

  instr_encoder_sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push_s),
    .data_i  (encoded_s),
    .pop_i   (pop_s),
    .data_o  (fifo_head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Session FSM plus write-address / count / error / done next-state logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    err_d   = err_q;
    done_d  = 1'b0;

    if (pop_s) begin
      addr_d = addr_q + 1'b1;
      if (count_q != '1) begin
        count_d = count_q + 1'b1;
      end else begin
        count_d = count_q;
      end
    end else begin
      addr_d  = addr_q;
      count_d = count_q;
    end

    case (state_q)
      ST_IDLE: begin
        // A start is only honoured once every earlier word has been written
        if (start_i && fifo_empty_s) begin
          state_d = ST_LOAD;
          addr_d  = base_addr_i;
          count_d = '0;
          err_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // An illegal op wins over a same-cycle finish
        if (illegal_s) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else if (finish_i) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty_s) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_ERR: begin
        if (fifo_empty_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ERR;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and session registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Outputs are taken from registers only
  assign bus.in_ready = in_ready_s;
  assign bus.wr_valid = !fifo_empty_s;
  assign bus.wr_data  = fifo_head_s;
  assign bus.wr_addr  = addr_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign count_o      = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: a queue-based behavioural model
// predicts every output each cycle; directed sessions pin the model with
// hand-encoded words, then a randomized phase exercises everything.
module tb_instr_encoder;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              reset_i;
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic              finish_i;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [ADDR_W:0]   count_o;

  always #5 clk = ~clk;

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus();

  instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .finish_i    (finish_i),
    .bus         (bus.slave),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .count_o     (count_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 loading, 2 draining after finish, 3 aborting after illegal op
  int          m_mode;
  logic [31:0] m_q[$];
  int          m_addr;
  int          m_count;
  bit          m_err;
  bit          m_done;
  bit          m_known = 1'b0;
  bit          m_acc;
  int          opc_tbl[7] = '{0, 8, 12, 13, 43, 35, 4};

  localparam int MEM_WORDS = 1 << ADDR_W;
  localparam int CNT_MAX   = (1 << (ADDR_W + 1)) - 1;

  function automatic logic [31:0] ref_encode(int op, int rs, int rt, int rd, int sh, int fn, int imm);
    longint w;
    if (op == 0) w = longint'(rs) * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + sh * (1 << 6) + fn;
    else         w = longint'(opc_tbl[op]) * (1 << 26) + longint'(rs) * (1 << 21) + rt * (1 << 16) + imm;
    return w[31:0];
  endfunction

  function automatic void check_outputs();
    int sz;
    if (!m_known) return;
    sz = m_q.size();
    chk("in_ready", bus.in_ready, (m_mode == 1 && sz < DEPTH));
    chk("wr_valid", bus.wr_valid, (sz > 0));
    if (sz > 0) chk("wr_data", bus.wr_data, m_q[0]);
    chk("wr_addr", bus.wr_addr, m_addr);
    chk("busy", busy_o, (m_mode != 0));
    chk("done", done_o, m_done);
    chk("err", err_o, m_err);
    chk("count", count_o, m_count);
  endfunction

  function automatic void model_step();
    int sz;
    bit ready;
    bit nxt_done;
    m_acc = 1'b0;
    if (reset_i) begin
      m_mode = 0; m_q.delete(); m_addr = 0; m_count = 0;
      m_err = 1'b0; m_done = 1'b0; m_known = 1'b1;
      return;
    end
    if (!m_known) return;
    sz       = m_q.size();
    ready    = (m_mode == 1 && sz < DEPTH);
    m_acc    = bus.in_valid && ready;
    nxt_done = 1'b0;
    if (sz > 0 && bus.wr_ready) begin
      void'(m_q.pop_front());
      m_addr = (m_addr + 1) % MEM_WORDS;
      if (m_count < CNT_MAX) m_count++;
    end
    case (m_mode)
      0: if (start_i && sz == 0) begin
           m_mode = 1; m_addr = int'(base_addr_i); m_count = 0; m_err = 1'b0;
         end
      1: if (m_acc && bus.in_op == 3'd7) begin
           m_mode = 3; m_err = 1'b1;
         end else begin
           if (m_acc)
             m_q.push_back(ref_encode(int'(bus.in_op), int'(bus.in_rs), int'(bus.in_rt), int'(bus.in_rd),
                                      int'(bus.in_shamt), int'(bus.in_funct), int'(bus.in_imm)));
           if (finish_i) m_mode = 2;
         end
      2: if (sz == 0) begin m_mode = 0; nxt_done = 1'b1; end
      3: if (sz == 0) m_mode = 0;
      default: m_mode = 0;
    endcase
    m_done = nxt_done;
  endfunction

  // ---------------- cycle driver ----------------
  logic [ADDR_W+31:0] cap[$];
  int                 done_cnt;

  task automatic tick();
    check_outputs();
    if (bus.wr_valid && bus.wr_ready) cap.push_back({bus.wr_addr, bus.wr_data});
    if (done_o) done_cnt++;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_fields(int op, int rs, int rt, int rd, int sh, int fn, int imm);
    bus.in_op = 3'(op); bus.in_rs = 5'(rs); bus.in_rt = 5'(rt); bus.in_rd = 5'(rd);
    bus.in_shamt = 5'(sh); bus.in_funct = 6'(fn); bus.in_imm = 16'(imm);
  endtask

  task automatic send(int op, int rs, int rt, int rd, int sh, int fn, int imm);
    bit got;
    got = 1'b0;
    drive_fields(op, rs, rt, rd, sh, fn, imm);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      got = m_acc;
    end
    bus.in_valid = 1'b0;
    chk("send_accepted", got, 1'b1);
  endtask

  task automatic begin_session(logic [ADDR_W-1:0] base);
    cap.delete(); done_cnt = 0;
    start_i = 1'b1; base_addr_i = base;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && !(m_mode == 0 && !m_done); i++) tick();
    chk("idle_reached", busy_o, 1'b0);
  endtask

  task automatic end_session();
    finish_i = 1'b1;
    tick();
    finish_i = 1'b0;
    wait_idle();
  endtask

  task automatic check_reset_values(string tag);
    chk({tag, "_wr_valid"}, bus.wr_valid, 1'b0);
    chk({tag, "_in_ready"}, bus.in_ready, 1'b0);
    chk({tag, "_wr_addr"}, bus.wr_addr, 0);
    chk({tag, "_wr_data"}, bus.wr_data, 0);
    chk({tag, "_busy"}, busy_o, 1'b0);
    chk({tag, "_done"}, done_o, 1'b0);
    chk({tag, "_err"}, err_o, 1'b0);
    chk({tag, "_count"}, count_o, 0);
  endtask

  logic [31:0] bp_words[3] = '{32'h34641234, 32'h30A600FF, 32'h00E84882};
  logic [31:0] held_data;

  initial begin
    int idx;
    reset_i = 1'b1; start_i = 1'b0; finish_i = 1'b0; base_addr_i = '0;
    bus.in_valid = 1'b0; bus.wr_ready = 1'b1;
    drive_fields(0, 0, 0, 0, 0, 0, 0);
    done_cnt = 0;
    @(negedge clk);
    tick(); tick();
    reset_i = 1'b0;
    check_reset_values("reset");

    // Single R-type word
    begin_session(10'h010);
    send(0, 1, 2, 3, 0, 'h20, 'h5A5A);
    end_session();
    chk("r_nwrites", cap.size(), 1);
    chk("r_word", cap[0], {10'h010, 32'h00221820});
    chk("r_done", done_cnt, 1);

    // I-type stream; unused fields carry junk
    begin_session(10'h100);
    send(1, 0, 8, 31, 31, 63, 5);
    send(5, 29, 9, 7, 3, 1, 4);
    send(4, 29, 9, 2, 9, 44, 8);
    send(6, 1, 2, 17, 5, 12, 'hFFFF);
    end_session();
    chk("i_nwrites", cap.size(), 4);
    chk("i_word0", cap[0], {10'h100, 32'h20080005});
    chk("i_word1", cap[1], {10'h101, 32'h8FA90004});
    chk("i_word2", cap[2], {10'h102, 32'hAFA90008});
    chk("i_word3", cap[3], {10'h103, 32'h1022FFFF});
    chk("i_count", count_o, 4);
    chk("i_done", done_cnt, 1);

    // Backpressure: imem stalls for 5 cycles
    bus.wr_ready = 1'b0;
    begin_session(10'h300);
    idx = 0;
    drive_fields(3, 3, 4, 0, 0, 0, 'h1234);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) held_data = bus.wr_data;
      tick();
      if (m_acc) begin
        idx++;
        if (idx == 1) drive_fields(2, 5, 6, 0, 0, 0, 'h00FF);
        else          drive_fields(0, 7, 8, 9, 2, 2, 0);
      end
    end
    chk("bp_pushes", idx, 2);
    chk("bp_in_ready", bus.in_ready, 1'b0);
    chk("bp_hold_data", bus.wr_data, held_data);
    chk("bp_hold_addr", bus.wr_addr, 10'h300);
    bus.wr_ready = 1'b1;
    for (int i = 0; i < 20 && idx < 3; i++) begin
      tick();
      if (m_acc) idx++;
    end
    bus.in_valid = 1'b0;
    end_session();
    chk("bp_nwrites", cap.size(), 3);
    for (int i = 0; i < 3; i++) chk("bp_word", cap[i], {10'(10'h300 + i), bp_words[i]});

    // Illegal op after two valid words
    begin_session(10'h200);
    send(1, 1, 1, 0, 0, 0, 1);
    send(5, 2, 3, 0, 0, 0, 'h10);
    send(7, 0, 0, 0, 0, 0, 0);
    chk("ill_err", err_o, 1'b1);
    chk("ill_in_ready", bus.in_ready, 1'b0);
    wait_idle();
    chk("ill_nwrites", cap.size(), 2);
    chk("ill_word0", cap[0], {10'h200, 32'h20210001});
    chk("ill_word1", cap[1], {10'h201, 32'h8C430010});
    chk("ill_no_done", done_cnt, 0);
    chk("ill_err_sticky", err_o, 1'b1);
    begin_session(10'h000);
    chk("ill_err_cleared", err_o, 1'b0);
    end_session();
    chk("empty_session_done", done_cnt, 1);

    // Address wrap
    begin_session(10'h3FF);
    send(3, 0, 1, 0, 0, 0, 'hABCD);
    send(6, 3, 3, 0, 0, 0, 2);
    end_session();
    chk("wrap_word0", cap[0], {10'h3FF, 32'h3401ABCD});
    chk("wrap_word1", cap[1], {10'h000, 32'h10630002});

    // Reset in the middle of a load with two words queued
    bus.wr_ready = 1'b0;
    begin_session(10'h050);
    send(1, 1, 2, 0, 0, 0, 3);
    send(2, 4, 5, 0, 0, 0, 6);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    check_reset_values("midreset");
    bus.wr_ready = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      reset_i      = ($urandom_range(0, 499) == 0);
      start_i      = ($urandom_range(0, 19) == 0);
      base_addr_i  = ADDR_W'($urandom);
      finish_i     = ($urandom_range(0, 24) == 0);
      bus.in_valid = $urandom_range(0, 1) == 1;
      drive_fields(($urandom_range(0, 15) == 0) ? 7 : int'($urandom_range(0, 6)),
                   int'($urandom), int'($urandom), int'($urandom), int'($urandom),
                   int'($urandom), int'($urandom));
      bus.wr_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    reset_i = 1'b0; start_i = 1'b0; finish_i = 1'b0;
    bus.in_valid = 1'b0; bus.wr_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
